rv32_mem_stage: RTL and testbench
=================================

Name: rv32_mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline.
- Sits between the EX/MEM queue and rv32_mem_wb_queue; its data_res_out drives that queue's data_res_in.
- Decodes load/store instructions and runs a ready/valid request/response transaction on the data-memory port.
- Stalls the pipeline while a transaction is outstanding, aligns and sign-extends load data, and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT_RSP before abort with bus error; 0 disables the timeout.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
code_in  input  32  current instruction from EX/MEM queue
addr_in  input  32  effective address (ALU result) from EX/MEM queue
store_data_in  input  32  rs2 value for stores
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  memory accepts request
dmem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
dmem_we  output  1  1=store, 0=load
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_rsp_valid  input  1  load response valid
dmem_rdata  input  32  load response word
data_res_out  output  32  formatted load result to MEM/WB
stall_out  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB captures a bubble
misalign_out  output  1  one-cycle misaligned-access flag
bus_err_out  output  1  one-cycle timeout flag

Behaviour:
- Decode: load = opcode 0000011, funct3 000/001/010/100/101 (LB/LH/LW/LBU/LHU). Store = opcode 0100011, funct3 000/001/010 (SB/SH/SW). Any other opcode or funct3 is a non-memory instruction and passes through with no stall.
- Misaligned:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- FSM states: IDLE, REQ, WAIT_RSP, DONE. Encoding is defined in the package.
- IDLE:
  - Aligned mem op: latch addr, we, be, wdata, funct3; go to REQ; stall_out=1 combinationally that cycle.
  - Misaligned op: misalign_out=1 for that cycle, no request, no stall, data_res_out=0, stay in IDLE.
  - Non-memory instruction: stay in IDLE, data_res_out=0.
- REQ:
  - dmem_req_valid=1 with latched fields held stable until ready.
  - On ready: store goes to DONE, load goes to WAIT_RSP.
  - No timeout in REQ.
- WAIT_RSP:
  - Counter increments each cycle.
  - rsp_valid: capture formatted data, go to DONE. The earliest response is the cycle after acceptance.
  - Counter reaches TIMEOUT_CYCLES with TIMEOUT_CYCLES!=0: captured data=0, set error flag, go to DONE.
  - rsp_valid has priority over timeout in the same cycle.
- DONE:
  - stall_out=0; data_res_out=captured value; bus_err_out=1 if the error flag is set.
  - Next cycle: IDLE, flag cleared.
  - DONE never re-triggers on the same code_in, because IDLE is evaluated only after the pipeline has advanced.
- stall_out = (IDLE & aligned mem op) | REQ | WAIT_RSP.
- Minimum latencies:
  - Store: 2 stall cycles.
  - Load: 3 stall cycles.
- Responses outside WAIT_RSP are ignored.
- Load format (off=addr[1:0]):
  - LB/LBU: byte off, sign-/zero-extended.
  - LH/LHU: half off[1], sign-/zero-extended.
  - LW: full word.
- Store format:
  - SB: be=1<<off, wdata={4{rs2[7:0]}}.
  - SH: be=off[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
  - For loads, dmem_be is driven with the access's byte lanes and is informational only.
- Reset, including mid-transaction:
  - State IDLE; counter, flags and all latched fields 0.
  - dmem_req_valid, stall_out, misalign_out, bus_err_out and data_res_out are 0 immediately (asynchronous).
  - An outstanding response arriving after reset is ignored.

Decomposition:
- Package rv32_mem_pkg holds:
  - Opcode constants OP_LOAD and OP_STORE.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - mem_state_t enum.
- Sub-module rv32_load_align: combinational; takes rdata, off, funct3 and returns the extracted/extended 32-bit result. It is reused by any future cache path.

Test Plan:
- LW at 0x100, ready=1, rsp 2 cycles after acceptance with rdata=0xCAFEBABE -> dmem_addr=0x100, be=1111, stall_out high 4 cycles, DONE data_res_out=0xCAFEBABE.
- SB at 0x203, rs2=0x000000A5, ready held low 3 cycles -> req_valid and fields stable throughout, be=1000, wdata=0xA5A5A5A5, we=1, stall released in DONE.
- LB at 0x2, rdata=0x00800000 -> data_res_out=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x2 with rdata=0x8001xxxx -> 0x00008001.
- LW at 0x102 -> misalign_out=1 for 1 cycle, no dmem_req_valid, stall_out=0. SH at 0x101 behaves the same, with no write issued.
- TIMEOUT_CYCLES=4, load accepted, no response -> DONE after 4 WAIT_RSP cycles, bus_err_out=1, data_res_out=0. A late rsp_valid is ignored.
- rst_n asserted while in WAIT_RSP -> req_valid and stall_out drop immediately, state IDLE. After release, ADDI code_in gives no stall.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared decode constants, FSM state type and the latched memory request
// for the RV32I memory-access stage.
package rv32_mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } mem_req_t;

  // Byte lanes touched by an access of size funct3[1:0] at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'b00:   store_lanes = {4{rs2[7:0]}};
      2'b01:   store_lanes = {2{rs2[15:0]}};
      default: store_lanes = rs2;
    endcase
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Extracts the addressed byte/halfword from a load response word and
// sign- or zero-extends it according to funct3.
module rv32_load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'h0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'h0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/rv32_mem_stage.sv
// RV32I memory-access stage: decodes loads/stores, runs one ready/valid
// transaction on the data port per instruction and stalls the pipe meanwhile.
module rv32_mem_stage
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] code_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] data_res_out,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  mem_state_t  state;
  mem_req_t    req;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic        err;
  logic [31:0] res;
  logic [31:0] aligned;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        is_load, is_store, mem_op, mis, go;
  logic        unused;

  assign opcode = code_in[6:0];
  assign f3     = code_in[14:12];
  assign off    = addr_in[1:0];
  assign unused = ^{code_in[31:15], code_in[11:7]};

  always_comb begin
    is_load  = (opcode == OP_LOAD) &&
               (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    is_store = (opcode == OP_STORE) && (f3 == F3_B || f3 == F3_H || f3 == F3_W);
    mem_op   = is_load | is_store;
    mis      = mem_op && (((f3[1:0] == 2'b01) && off[0]) ||
                          ((f3[1:0] == 2'b10) && (off != 2'b00)));
    go       = mem_op & ~mis;
  end

  assign cnt_nxt = cnt + CW'(1);

  rv32_load_align u_align (
    .rdata  (dmem_rdata),
    .off    (req.addr[1:0]),
    .funct3 (req.funct3),
    .result (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      req   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            req.addr   <= addr_in;
            req.we     <= is_store;
            req.be     <= lane_mask(f3, off);
            req.wdata  <= store_lanes(f3, store_data_in);
            req.funct3 <= f3;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            cnt   <= '0;
            state <= req.we ? S_DONE : S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          // A response in the same cycle as the timeout still wins.
          if (dmem_rsp_valid) begin
            res   <= aligned;
            state <= S_DONE;
          end else begin
            cnt <= cnt_nxt;
            if (TIMEOUT_CYCLES != 0 && cnt_nxt == TMO) begin
              res   <= '0;
              err   <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          res   <= '0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dmem_req_valid = (state == S_REQ);
  assign dmem_addr      = {req.addr[31:2], 2'b00};
  assign dmem_we        = req.we;
  assign dmem_be        = req.be;
  assign dmem_wdata     = req.wdata;

  // Decode-driven outputs are gated by rst_n so they drop the moment reset asserts.
  assign stall_out    = rst_n & (((state == S_IDLE) & go) | (state == S_REQ) |
                                 (state == S_WAIT_RSP));
  assign misalign_out = rst_n & (state == S_IDLE) & mis;
  assign bus_err_out  = (state == S_DONE) & err;
  assign data_res_out = (state == S_DONE) ? res : 32'h0;

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Randomized bench for rv32_mem_stage: a transaction-level model plans each
// instruction's cycles and a negedge process compares the DUT against it.
module tb_rv32_mem_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] code_in, addr_in, store_data_in;
  logic        dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic [31:0] data_res_out;
  logic        stall_out, misalign_out, bus_err_out;

  rv32_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .addr_in(addr_in),
    .store_data_in(store_data_in), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata), .data_res_out(data_res_out), .stall_out(stall_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;
  bit chk_en = 1'b0;

  bit          exp_stall, exp_req, exp_mis, exp_err, exp_we;
  logic [31:0] exp_data, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && stall_out === 1'b1) stall_cnt++;
    if (chk_en && rst_n) begin
      chk("stall", {31'h0, stall_out}, {31'h0, exp_stall});
      chk("req_valid", {31'h0, dmem_req_valid}, {31'h0, exp_req});
      chk("misalign", {31'h0, misalign_out}, {31'h0, exp_mis});
      chk("bus_err", {31'h0, bus_err_out}, {31'h0, exp_err});
      if (!exp_stall) chk("data_res", data_res_out, exp_data);
      if (exp_req) begin
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_we", {31'h0, dmem_we}, {31'h0, exp_we});
        chk("dmem_be", {28'h0, dmem_be}, {28'h0, exp_be});
        if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  // ---- behavioural model: accesses described by size in bytes ----
  function automatic int acc_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    int n = acc_bytes(f3);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int n = acc_bytes(f3);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    int n = acc_bytes(f3);
    logic [31:0] s = w >> (8 * off);
    logic signed [7:0]  sb = s[7:0];
    logic signed [15:0] sh = s[15:0];
    int v;
    if (n == 4) return w;
    if (f3[2]) return (n == 1) ? {24'h0, s[7:0]} : {16'h0, s[15:0]};
    v = (n == 1) ? int'(sb) : int'(sh);
    return v;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'd1, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    exp_stall = 0; exp_req = 0; exp_mis = 0; exp_err = 0; exp_we = 0;
    exp_data = '0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
  endtask

  // Plays one instruction through the stage and sets per-cycle expectations.
  task automatic run_op(input logic [31:0] code, input logic [31:0] addr,
                        input logic [31:0] rs2, input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rdata);
    logic [6:0] op;
    logic [2:0] f3;
    bit ld, st, mis, err;
    int n;
    logic [31:0] data;
    op = code[6:0];
    f3 = code[14:12];
    ld = (op == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st = (op == 7'b0100011) && (f3 inside {3'd0, 3'd1, 3'd2});
    n = acc_bytes(f3);
    mis = (ld || st) && ((int'(addr[1:0]) % n) != 0);
    code_in = code; addr_in = addr; store_data_in = rs2;
    clear_exp();
    dmem_req_ready = 1'($urandom); dmem_rsp_valid = 1'($urandom); dmem_rdata = $urandom;
    if (!(ld || st) || mis) begin
      exp_mis = mis;
      tick();
      return;
    end
    exp_stall = 1;
    tick();
    for (int i = 0; i <= rdy_dly; i++) begin
      exp_req = 1; exp_addr = {addr[31:2], 2'b00}; exp_we = st;
      exp_be = m_be(f3, addr[1:0]); exp_wdata = m_wdata(f3, rs2);
      dmem_req_ready = (i == rdy_dly);
      dmem_rsp_valid = 1'($urandom); dmem_rdata = $urandom;
      tick();
    end
    exp_req = 0;
    data = '0; err = 0;
    if (ld) begin
      for (int i = 1; i <= 64; i++) begin
        dmem_req_ready = 1'($urandom);
        if (i == rsp_dly) begin
          dmem_rsp_valid = 1; dmem_rdata = rdata;
          data = m_load(f3, addr[1:0], rdata);
          tick();
          break;
        end
        dmem_rsp_valid = 0; dmem_rdata = $urandom;
        tick();
        if (i == TMO) begin err = 1; break; end
      end
    end
    exp_stall = 0; exp_data = data; exp_err = err;
    dmem_rsp_valid = err ? 1'b1 : 1'($urandom); dmem_rdata = $urandom;
    tick();
  endtask

  logic [31:0] c;
  logic [2:0]  rf3;
  logic [6:0]  rop;
  logic [31:0] ra;

  initial begin
    rst_n = 0;
    code_in = mk(7'b0000011, 3'b010); addr_in = 32'h100; store_data_in = 32'h1234;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
    clear_exp();
    #3;
    chk("rst_stall", {31'h0, stall_out}, 32'h0);
    chk("rst_req_valid", {31'h0, dmem_req_valid}, 32'h0);
    chk("rst_data", data_res_out, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be_we", {27'h0, dmem_we, dmem_be}, 32'h0);
    chk("rst_flags", {30'h0, misalign_out, bus_err_out}, 32'h0);
    code_in = mk(7'b0010011, 3'b000);
    #9 rst_n = 1;
    tick();
    chk_en = 1;

    // model pins
    chk("pin_lb", m_load(3'b000, 2'd2, 32'h00800000), 32'hFFFFFF80);
    chk("pin_lbu", m_load(3'b100, 2'd2, 32'h00800000), 32'h00000080);
    chk("pin_lhu", m_load(3'b101, 2'd2, 32'h80011234), 32'h00008001);
    chk("pin_sb_be", {28'h0, m_be(3'b000, 2'd3)}, 32'h8);
    chk("pin_sb_wd", m_wdata(3'b000, 32'h000000A5), 32'hA5A5A5A5);

    // directed plan
    stall_cnt = 0;
    run_op(mk(7'b0000011, 3'b010), 32'h100, 0, 0, 2, 32'hCAFEBABE);
    chk("lw_stall_cycles", stall_cnt, 32'd4);
    stall_cnt = 0;
    run_op(mk(7'b0100011, 3'b000), 32'h203, 32'h000000A5, 3, 1, 0);
    chk("sb_stall_cycles", stall_cnt, 32'd5);
    run_op(mk(7'b0000011, 3'b000), 32'h2, 0, 0, 1, 32'h00800000);
    run_op(mk(7'b0000011, 3'b100), 32'h2, 0, 1, 3, 32'h00800000);
    run_op(mk(7'b0000011, 3'b101), 32'h2, 0, 0, 1, 32'h80011234);
    run_op(mk(7'b0000011, 3'b010), 32'h102, 0, 0, 1, 0);
    run_op(mk(7'b0100011, 3'b001), 32'h101, 32'hFFFF, 0, 1, 0);
    run_op(mk(7'b0000011, 3'b010), 32'h40, 0, 0, 99, 32'hDEADBEEF);
    run_op(mk(7'b0000011, 3'b010), 32'h44, 0, 0, TMO, 32'h13572468);
    run_op(mk(7'b0010011, 3'b000), 32'h0, 0, 0, 1, 0);

    // random traffic
    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(5, 0))
        0, 1: begin
          rop = 7'b0000011;
          case ($urandom_range(4, 0))
            0: rf3 = 3'd0; 1: rf3 = 3'd1; 2: rf3 = 3'd2; 3: rf3 = 3'd4; default: rf3 = 3'd5;
          endcase
        end
        2: begin rop = 7'b0100011; rf3 = 3'($urandom_range(2, 0)); end
        3: begin
          rop = 7'b0000011;
          case ($urandom_range(2, 0)) 0: rf3 = 3'd3; 1: rf3 = 3'd6; default: rf3 = 3'd7; endcase
        end
        4: begin rop = 7'b0100011; rf3 = 3'($urandom_range(7, 3)); end
        default: begin
          rop = 7'($urandom);
          if (rop == 7'b0000011 || rop == 7'b0100011) rop = 7'b0010011;
          rf3 = 3'($urandom);
        end
      endcase
      c = $urandom; c[14:12] = rf3; c[6:0] = rop;
      ra = $urandom;
      if ($urandom_range(1, 0) == 0) ra[1:0] = 2'b00;
      run_op(c, ra, $urandom, $urandom_range(3, 0), $urandom_range(6, 1), $urandom);
    end

    // reset while waiting for a load response
    chk_en = 0;
    code_in = mk(7'b0000011, 3'b010); addr_in = 32'h80; dmem_req_ready = 1; dmem_rsp_valid = 0;
    tick();
    tick();
    chk("wait_stall", {31'h0, stall_out}, 32'h1);
    #2 rst_n = 0;
    #1;
    chk("arst_req_valid", {31'h0, dmem_req_valid}, 32'h0);
    chk("arst_stall", {31'h0, stall_out}, 32'h0);
    chk("arst_data", data_res_out, 32'h0);
    tick();
    #1 rst_n = 1;
    clear_exp();
    code_in = mk(7'b0010011, 3'b000); dmem_rsp_valid = 1; dmem_rdata = 32'hFEEDF00D;
    chk_en = 1;
    tick();
    dmem_rsp_valid = 0;
    tick();
    run_op(mk(7'b0000011, 3'b001), 32'h86, 0, 1, 2, 32'hBEEF0000);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
